serial_add_ctrl: RTL and testbench

// - Sequencer that time-shares ONE half_adder instance to perform a WIDTH-bit

---
 rtl/serial_add_ctrl_pkg.sv | 12 +
 rtl/serial_add_ctrl_half_adder.sv | 12 +
 rtl/serial_add_ctrl.sv | 111 +++++++++++
 tb/tb_serial_add_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared types for the bit-serial adder sequencer.
// Holds the FSM state encoding used by serial_add_ctrl.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PH0  = 2'd1,
        ST_PH1  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_half_adder.sv
// Single-bit half adder; the only arithmetic element the sequencer time-shares.
module half_adder (
    input  logic A,
    input  logic B,
    output logic Sum,
    output logic Carry
);

    assign Sum   = A ^ B;
    assign Carry = A & B;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit unsigned adder, LSB first, built from one half_adder
// used twice per bit (operand pass, then carry pass).
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q, sum_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q, s1_q, c1_q, cout_q;
    logic               ha_a, ha_b, ha_sum, ha_carry;

    half_adder u_ha (
        .A     (ha_a),
        .B     (ha_b),
        .Sum   (ha_sum),
        .Carry (ha_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_PH0;
            ST_PH0:  state_d = ST_PH1;
            ST_PH1:  state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_PH0;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Half-adder inputs are held at 0 outside PH0/PH1 to avoid needless toggling.
    always_comb begin
        ha_a = 1'b0;
        ha_b = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_PH0: begin
                ha_a = a_q[idx_q];
                ha_b = b_q[idx_q];
                busy = 1'b1;
            end
            ST_PH1: begin
                ha_a = s1_q;
                ha_b = carry_q;
                busy = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            s1_q    <= 1'b0;
            c1_q    <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    a_q     <= A;
                    b_q     <= B;
                    idx_q   <= '0;
                    carry_q <= 1'b0;
                    sum_q   <= '0;
                    cout_q  <= 1'b0;
                end
                ST_PH0: begin
                    s1_q <= ha_sum;
                    c1_q <= ha_carry;
                end
                ST_PH1: begin
                    sum_q[idx_q] <= ha_sum;
                    carry_q      <= c1_q | ha_carry;
                    if (idx_q == LAST_IDX) cout_q <= c1_q | ha_carry;
                    else                   idx_q  <= idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Sum  = sum_q;
    assign Cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=4 and WIDTH=8 against an
// arithmetic model of {Cout,Sum} = A+B and the 2*WIDTH-cycle latency rule.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start4 = 1'b0, start8 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, sum4;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       busy4, done4, cout4, busy8, done8, cout8;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4),
        .busy(busy4), .done(done4), .Sum(sum4), .Cout(cout4)
    );

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .Sum(sum8), .Cout(cout8)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_busy(input int w);
        return (w == 4) ? 32'(busy4) : 32'(busy8);
    endfunction
    function automatic logic [31:0] get_done(input int w);
        return (w == 4) ? 32'(done4) : 32'(done8);
    endfunction
    function automatic logic [31:0] get_sum(input int w);
        return (w == 4) ? 32'(sum4) : 32'(sum8);
    endfunction
    function automatic logic [31:0] get_cout(input int w);
        return (w == 4) ? 32'(cout4) : 32'(cout8);
    endfunction

    task automatic set_in(input int w, input int a, input int b, input logic s);
        if (w == 4) begin
            a4 = a[3:0]; b4 = b[3:0]; start4 = s;
        end else begin
            a8 = a[7:0]; b8 = b[7:0]; start8 = s;
        end
    endtask

    // One operation: accept at edge k, then check busy/done after every edge
    // k+j. repoke>0 re-asserts start (A=B=1) for edge k+repoke; rst_at>=0
    // asserts reset after edge k+rst_at and abandons the operation.
    task automatic run_op(input int w, input int a, input int b,
                          input int repoke, input int rst_at);
        int mask, total, exp_sum, exp_cout;
        mask     = (1 << w) - 1;
        total    = (a & mask) + (b & mask);
        exp_sum  = total & mask;
        exp_cout = (total >> w) & 1;

        @(negedge clk);
        set_in(w, a, b, 1'b1);
        @(posedge clk);
        for (int j = 0; j <= 2 * w + 1; j++) begin
            @(negedge clk);
            if (j == rst_at) begin
                rst_n = 1'b0;
                set_in(w, 0, 0, 1'b0);
                #1;
                check_val("rst_busy", get_busy(w), 0);
                check_val("rst_done", get_done(w), 0);
                check_val("rst_sum",  get_sum(w),  0);
                check_val("rst_cout", get_cout(w), 0);
                repeat (2) begin
                    @(negedge clk);
                    check_val("rst_no_done", get_done(w), 0);
                end
                rst_n = 1'b1;
                return;
            end
            check_val($sformatf("busy_w%0d_c%0d", w, j), get_busy(w), 32'(j < 2 * w));
            check_val($sformatf("done_w%0d_c%0d", w, j), get_done(w), 32'(j == 2 * w));
            if (j == 2 * w) begin
                check_val($sformatf("sum_w%0d_%0d+%0d", w, a & mask, b & mask), get_sum(w), 32'(exp_sum));
                check_val($sformatf("cout_w%0d_%0d+%0d", w, a & mask, b & mask), get_cout(w), 32'(exp_cout));
            end
            if (j + 1 == repoke) set_in(w, 1, 1, 1'b1);
            else                 set_in(w, int'($urandom), int'($urandom), 1'b0);
        end
        repeat (3) @(negedge clk);
        check_val("sum_held",  get_sum(w),  32'(exp_sum));
        check_val("cout_held", get_cout(w), 32'(exp_cout));
        check_val("idle_busy", get_busy(w), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_val("reset_busy4", 32'(busy4), 0);
        check_val("reset_done4", 32'(done4), 0);
        check_val("reset_sum4",  32'(sum4),  0);
        check_val("reset_cout4", 32'(cout4), 0);
        check_val("reset_busy8", 32'(busy8), 0);
        check_val("reset_done8", 32'(done8), 0);
        check_val("reset_sum8",  32'(sum8),  0);
        check_val("reset_cout8", 32'(cout8), 0);

        run_op(4, 5, 3, 0, -1);
        run_op(4, 15, 1, 0, -1);
        run_op(4, 0, 0, 0, -1);
        run_op(4, 9, 6, 3, -1);
        run_op(4, 7, 7, 0, 4);
        run_op(4, 2, 2, 0, -1);
        for (int i = 0; i < 20; i++)
            run_op(4, int'($urandom_range(15)), int'($urandom_range(15)), 0, -1);

        run_op(8, 200, 100, 0, -1);
        run_op(8, 255, 255, 0, -1);
        run_op(8, 255, 1, 5, -1);
        for (int i = 0; i < 40; i++)
            run_op(8, int'($urandom_range(255)), int'($urandom_range(255)), 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
